// File: rtl/alu_issue_stage.sv
// Registered issue stage: decodes RV32I OP / OP-IMM into ALU controls behind a two-entry skid buffer.
// Define ALU_ISSUE_IMM_EN to enable OP-IMM decode; otherwise opcode 0010011 is flagged illegal.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1Data,
  input  logic [31:0]      rs2Data,
  output logic             outValid,
  input  logic             outReady,
  output logic [31:0]      operandA,
  output logic [31:0]      operandB,
  output logic [2:0]       ALUOp,
  output logic [4:0]       rdAddr,
  output logic             illegal,
  output logic [CNT_W-1:0] illegalCount
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } beat_t;

`ifdef ALU_ISSUE_IMM_EN
  function automatic logic signed [31:0] sext_imm12(input logic signed [11:0] imm);
    return 32'(imm);
  endfunction
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       ok;
  logic       unused_bits;
  beat_t      dec_p0;
  beat_t      out_p1;
  beat_t      skid_p1;
  logic       vld_p1;
  logic       skid_full;
  logic       accept;
  logic       out_free;
  logic [CNT_W-1:0] cnt;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  // rs1/rs2 addresses were consumed by the register-file read ahead of this stage.
  assign unused_bits = ^{instr[19:15], instr[24:20]};

  // p0: combinational decode of the incoming beat
  always_comb begin
    ok        = 1'b0;
    dec_p0    = '0;
    dec_p0.rd = instr[11:7];
    unique case (opc)
      7'b0110011: begin
        dec_p0.b = rs2Data;
        unique case (f3)
          3'b000: begin
            if (f7 == F7_ZERO)     begin ok = 1'b1; dec_p0.op = OP_ADD; end
            else if (f7 == F7_ALT) begin ok = 1'b1; dec_p0.op = OP_SUB; end
          end
          3'b001: if (f7 == F7_ZERO) begin ok = 1'b1; dec_p0.op = OP_SLL; end
          3'b100: if (f7 == F7_ZERO) begin ok = 1'b1; dec_p0.op = OP_XOR; end
          3'b110: if (f7 == F7_ZERO) begin ok = 1'b1; dec_p0.op = OP_OR;  end
          3'b111: if (f7 == F7_ZERO) begin ok = 1'b1; dec_p0.op = OP_AND; end
          3'b101: begin
            if (f7 == F7_ZERO)     begin ok = 1'b1; dec_p0.op = OP_SRL; end
            else if (f7 == F7_ALT) begin ok = 1'b1; dec_p0.op = OP_SRA; end
          end
          default: ok = 1'b0;
        endcase
      end
`ifdef ALU_ISSUE_IMM_EN
      7'b0010011: begin
        dec_p0.b = sext_imm12(instr[31:20]);
        unique case (f3)
          3'b000: begin ok = 1'b1; dec_p0.op = OP_ADD; end
          3'b100: begin ok = 1'b1; dec_p0.op = OP_XOR; end
          3'b110: begin ok = 1'b1; dec_p0.op = OP_OR;  end
          3'b111: begin ok = 1'b1; dec_p0.op = OP_AND; end
          3'b001: begin
            dec_p0.b = {27'b0, instr[24:20]};
            if (f7 == F7_ZERO) begin ok = 1'b1; dec_p0.op = OP_SLL; end
          end
          3'b101: begin
            dec_p0.b = {27'b0, instr[24:20]};
            if (f7 == F7_ZERO)     begin ok = 1'b1; dec_p0.op = OP_SRL; end
            else if (f7 == F7_ALT) begin ok = 1'b1; dec_p0.op = OP_SRA; end
          end
          default: ok = 1'b0;
        endcase
      end
`endif
      default: ok = 1'b0;
    endcase
    dec_p0.a = rs1Data;
    if (!ok) begin
      dec_p0.op = OP_ADD;
      dec_p0.a  = '0;
      dec_p0.b  = '0;
    end
    dec_p0.ill = !ok;
  end

  assign accept   = inValid && !skid_full;
  assign out_free = !vld_p1 || outReady;

  // p1: output register, skid register and illegal counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      skid_full <= 1'b0;
      out_p1    <= '0;
      cnt       <= '0;
    end else begin
      if (out_free) begin
        if (skid_full) begin
          out_p1    <= skid_p1;
          vld_p1    <= 1'b1;
          skid_full <= 1'b0;
        end else begin
          vld_p1 <= accept;
          if (accept) out_p1 <= dec_p0;
        end
      end else if (accept) begin
        skid_full <= 1'b1;
      end
      if (accept && dec_p0.ill) cnt <= sat_inc(cnt);
    end
  end

  // Skid data needs no reset: it is only observed while skid_full is set.
  always_ff @(posedge clk) begin
    if (accept && !out_free) skid_p1 <= dec_p0;
  end

  assign inReady      = !skid_full;
  assign outValid     = vld_p1;
  assign ALUOp        = out_p1.op;
  assign operandA     = out_p1.a;
  assign operandB     = out_p1.b;
  assign rdAddr       = out_p1.rd;
  assign illegal      = out_p1.ill;
  assign illegalCount = cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Table-driven scoreboard bench for alu_issue_stage (small counter width to reach saturation).
module tb_alu_issue_stage;

  localparam int CW = 3;
  localparam int NV = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          inValid;
  logic          inReady;
  logic [31:0]   instr;
  logic [31:0]   rs1Data;
  logic [31:0]   rs2Data;
  logic          outValid;
  logic          outReady;
  logic [31:0]   operandA;
  logic [31:0]   operandB;
  logic [2:0]    ALUOp;
  logic [4:0]    rdAddr;
  logic          illegal;
  logic [CW-1:0] illegalCount;

  alu_issue_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .instr(instr),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .outValid(outValid), .outReady(outReady),
    .operandA(operandA), .operandB(operandB), .ALUOp(ALUOp), .rdAddr(rdAddr),
    .illegal(illegal), .illegalCount(illegalCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t          tbl[NV];
  vec_t          q[$];
  vec_t          cur;
  vec_t          mon_e;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          hold = 1'b0;
  logic [73:0]   snap;
  logic          done;

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic ill);
    vec_t v;
    v.instr = i; v.rs1 = r1; v.rs2 = r2; v.op = op; v.a = a; v.b = b;
    v.rd = i[11:7]; v.ill = ill;
    return v;
  endfunction

  function automatic vec_t bad(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    return mk(i, r1, r2, 3'd0, 32'd0, 32'd0, 1'b1);
  endfunction

  // Monitor / scoreboard: inputs and outputs are stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        exp_cnt = '0;
        hold    = 1'b0;
      end else begin
        if (hold) begin
          n_chk++;
          if ({ALUOp, operandA, operandB, rdAddr, illegal, outValid} !== snap) begin
            n_fail++;
            $display("FAIL hold_stable got=%h expected=%h", {ALUOp, operandA, operandB, rdAddr, illegal, outValid}, snap);
          end
        end
        n_chk++;
        if (illegalCount !== exp_cnt) begin
          n_fail++;
          $display("FAIL illegal_count got=%0d expected=%0d", illegalCount, exp_cnt);
        end
        if (outValid && outReady) begin
          n_chk++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat got op=%0d a=%h b=%h rd=%0d ill=%b expected no beat",
                     ALUOp, operandA, operandB, rdAddr, illegal);
          end else begin
            mon_e = q.pop_front();
            if ({ALUOp, operandA, operandB, rdAddr, illegal} !== {mon_e.op, mon_e.a, mon_e.b, mon_e.rd, mon_e.ill}) begin
              n_fail++;
              $display("FAIL beat instr=%h got op=%0d a=%h b=%h rd=%0d ill=%b expected op=%0d a=%h b=%h rd=%0d ill=%b",
                       mon_e.instr, ALUOp, operandA, operandB, rdAddr, illegal,
                       mon_e.op, mon_e.a, mon_e.b, mon_e.rd, mon_e.ill);
            end
          end
        end
        if (inValid && inReady) begin
          q.push_back(cur);
          if (cur.ill && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
        hold = outValid && !outReady;
        snap = {ALUOp, operandA, operandB, rdAddr, illegal, outValid};
      end
    end
  end

  task automatic send(input vec_t v);
    int k;
    cur     = v;
    instr   = v.instr;
    rs1Data = v.rs1;
    rs2Data = v.rs2;
    inValid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (inReady) break;
    end
    if (k == 50) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout instr=%h got inReady=0 expected 1", v.instr);
    end
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    outReady = 1'b1;
    for (k = 0; k < 60; k++) begin
      @(posedge clk); #2;
      if (q.size() == 0 && !outValid && inReady) break;
    end
    n_chk++;
    if (k == 60) begin
      n_fail++;
      $display("FAIL drain_timeout got pending=%0d expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(32'h40208033, 32'd10, 32'd3, 3'd1, 32'd10, 32'd3, 1'b0);                       // SUB
    tbl[1]  = mk(32'h002081B3, 32'h7FFFFFFF, 32'd1, 3'd0, 32'h7FFFFFFF, 32'd1, 1'b0);           // ADD
    tbl[2]  = mk(32'h00209233, 32'h1234, 32'd40, 3'd5, 32'h1234, 32'd40, 1'b0);                 // SLL
    tbl[3]  = mk(32'h0020C2B3, 32'hA5A5A5A5, 32'h0F0F0F0F, 3'd4, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0); // XOR
    tbl[4]  = mk(32'h0020E333, 32'h00FF0000, 32'h000000FF, 3'd3, 32'h00FF0000, 32'h000000FF, 1'b0); // OR
    tbl[5]  = mk(32'h0020F3B3, 32'hFFFF0000, 32'h12345678, 3'd2, 32'hFFFF0000, 32'h12345678, 1'b0); // AND
    tbl[6]  = mk(32'h0020D433, 32'h80000000, 32'd4, 3'd6, 32'h80000000, 32'd4, 1'b0);           // SRL
    tbl[7]  = mk(32'h4020D4B3, 32'h80000000, 32'd4, 3'd7, 32'h80000000, 32'd4, 1'b0);           // SRA
    tbl[8]  = bad(32'h0020A533, 32'd9, 32'd8);                                                   // SLT
    tbl[9]  = bad(32'h022085B3, 32'd9, 32'd8);                                                   // ADD funct7 0000001
    tbl[10] = bad(32'h4020C633, 32'd9, 32'd8);                                                   // XOR funct7 0100000
    tbl[11] = bad(32'h000006EF, 32'd9, 32'd8);                                                   // JAL opcode
`ifdef ALU_ISSUE_IMM_EN
    tbl[12] = mk(32'hFFF08093, 32'd5, 32'd77, 3'd0, 32'd5, 32'hFFFFFFFF, 1'b0);                 // ADDI -1
    tbl[13] = mk(32'h4040D093, 32'hF0000000, 32'd77, 3'd7, 32'hF0000000, 32'd4, 1'b0);          // SRAI 4
    tbl[15] = mk(32'h7F00C113, 32'h0000FFFF, 32'd77, 3'd4, 32'h0000FFFF, 32'h000007F0, 1'b0);   // XORI 0x7F0
    tbl[16] = mk(32'h01F09193, 32'd1, 32'd77, 3'd5, 32'd1, 32'd31, 1'b0);                       // SLLI 31
    tbl[19] = mk(32'h8000F313, 32'hDEADBEEF, 32'd77, 3'd2, 32'hDEADBEEF, 32'hFFFFF800, 1'b0);   // ANDI -2048
`else
    tbl[12] = bad(32'hFFF08093, 32'd5, 32'd77);
    tbl[13] = bad(32'h4040D093, 32'hF0000000, 32'd77);
    tbl[15] = bad(32'h7F00C113, 32'h0000FFFF, 32'd77);
    tbl[16] = bad(32'h01F09193, 32'd1, 32'd77);
    tbl[19] = bad(32'h8000F313, 32'hDEADBEEF, 32'd77);
`endif
    tbl[14] = bad(32'h4240D093, 32'd6, 32'd77);                                                  // SRAI funct7 0100001
    tbl[17] = bad(32'h0050A213, 32'd6, 32'd77);                                                  // SLTI
    tbl[18] = bad(32'h41F09293, 32'd6, 32'd77);                                                  // SLLI funct7 0100000

    rst = 1'b1; inValid = 1'b0; outReady = 1'b1;
    instr = '0; rs1Data = '0; rs2Data = '0; cur = tbl[0];
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({outValid, inReady, ALUOp, operandA, operandB, rdAddr, illegal, illegalCount} !== {1'b0, 1'b1, 76'd0}) begin
      n_fail++;
      $display("FAIL reset_state got v=%b rdy=%b op=%0d a=%h b=%h rd=%0d ill=%b cnt=%0d expected rdy=1 rest 0",
               outValid, inReady, ALUOp, operandA, operandB, rdAddr, illegal, illegalCount);
    end
    rst = 1'b0;

    // Full-throughput pass
    for (int i = 0; i < NV; i++) send(tbl[i]);
    wait_idle();

    // Pass under random backpressure; counter saturates here
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < NV; i++) send(tbl[i]);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          outReady = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_idle();

    // Four back-to-back beats against a stalled output
    outReady = 1'b0;
    fork
      begin
        send(mk(32'h40208033, 32'd100, 32'd30, 3'd1, 32'd100, 32'd30, 1'b0));
        send(mk(32'h002081B3, 32'd200, 32'd7, 3'd0, 32'd200, 32'd7, 1'b0));
        send(bad(32'h0020A533, 32'd300, 32'd1));
        send(bad(32'h000006EF, 32'd400, 32'd2));
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (!(outValid === 1'b1 && inReady === 1'b0 && operandA === 32'd100)) begin
          n_fail++;
          $display("FAIL backpressure_state got v=%b rdy=%b a=%0d expected v=1 rdy=0 a=100",
                   outValid, inReady, operandA);
        end
        @(posedge clk); #1;
        outReady = 1'b1;
      end
    join
    wait_idle();

    // Reset with both registers occupied
    outReady = 1'b0;
    send(tbl[8]);
    send(tbl[0]);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({outValid, inReady, ALUOp, operandA, operandB, rdAddr, illegal, illegalCount} !== {1'b0, 1'b1, 76'd0}) begin
      n_fail++;
      $display("FAIL midstream_reset got v=%b rdy=%b op=%0d a=%h b=%h rd=%0d ill=%b cnt=%0d expected rdy=1 rest 0",
               outValid, inReady, ALUOp, operandA, operandB, rdAddr, illegal, illegalCount);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    outReady = 1'b1;
    send(tbl[1]);
    wait_idle();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered issue stage that drives the ALU. It decodes RV32I OP and OP-IMM instruction words into `ALUOp`, `operandA` and `operandB`, the exact encoding the ALU consumes. It sits between register-file read and the ALU. Valid/ready handshakes and a two-entry skid buffer give full throughput with a registered `inReady`. Unsupported encodings are flagged and counted.

## Interface
- `CNT_W`, default 16: width of the illegal-instruction counter.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inValid`  in  1  upstream beat valid.
- `inReady`  out  1  stage can accept a beat; registered.
- `instr`  in  32  instruction word.
- `rs1Data`  in  32  rs1 register value.
- `rs2Data`  in  32  rs2 register value.
- `outValid`  out  1  issued beat valid.
- `outReady`  in  1  ALU/writeback side accepts the beat.
- `operandA`  out  32  ALU operand A.
- `operandB`  out  32  ALU operand B.
- `ALUOp`  out  3  ALU operation select.
- `rdAddr`  out  5  destination register, `instr[11:7]`.
- `illegal`  out  1  beat holds an unsupported encoding.
- `illegalCount`  out  `CNT_W`  saturating count of accepted illegal beats.

## Operation
- ALUOp encoding:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL
  - 110 SRL
  - 111 SRA
- OP instructions (opcode `0110011`), with `funct7 = instr[31:25]` and `funct3 = instr[14:12]`:
  - 000: funct7 0000000 → ADD; funct7 0100000 → SUB.
  - 001 → SLL; 100 → XOR; 110 → OR; 111 → AND. Each requires funct7 0000000.
  - 101: funct7 0000000 → SRL; funct7 0100000 → SRA.
  - Operands: `operandA = rs1Data`, `operandB = rs2Data`.
- OP-IMM instructions (opcode `0010011`):
  - Immediate is `instr[31:20]`, sign-extended to 32 bits.
  - 000 → ADD; 100 → XOR; 110 → OR; 111 → AND. funct7 bits are ignored for these.
  - 001 → SLL; requires `instr[31:25]` = 0000000.
  - 101: `instr[31:25]` 0000000 → SRL; 0100000 → SRA.
  - Shifts: `operandB = {27'b0, instr[24:20]}`. Others: `operandB` = sign-extended immediate.
  - `operandA = rs1Data`.
- Illegal cases:
  - Which encodings: any other opcode; funct3 010 or 011 (SLT/SLTU); any funct7 mismatch above.
  - Beat output: the beat still issues, with `illegal = 1`, `ALUOp = 000`, operands 0 and `rdAddr` forwarded. Downstream suppresses writeback.
  - Counter: `illegalCount` increments by 1 when an illegal beat is accepted and saturates at all-ones.
- Buffering uses an output register plus one skid register. Beat order is always preserved.

## Timing
- Reset values: `outValid` 0, `inReady` 1, `operandA` 0, `operandB` 0, `ALUOp` 000, `rdAddr` 0, `illegal` 0, `illegalCount` 0. Asserting `rst` at any time discards all held beats.
- A transfer occurs on an edge where `valid && ready` are both high, on either port.
- Latency: a beat accepted at edge N appears on the outputs after edge N (visible in cycle N+1) when the output register is free.
- While `outValid && !outReady`, all outputs hold stable.
- Output register free: it is free when empty, or when it drains on the same edge. An accepted beat then loads directly into it; simultaneous drain and accept sustains 1 beat/cycle.
- Output register held: an accepted beat goes to the skid register, and `inReady` drops in the following cycle.
- Skid drain: when the output drains while the skid register is full, the skid beat moves to the output on that edge. `inReady` is 1 again in the following cycle.
- `inReady = !skidFull`. It never depends combinationally on `outReady`.
- Upstream obligation: `inValid` and its data must not be withdrawn before acceptance.

## Configuration
- `ALU_ISSUE_IMM_EN` defined: OP-IMM decode as specified above.
- `ALU_ISSUE_IMM_EN` undefined: opcode `0010011` is treated as illegal, and the immediate-generation logic is removed.

## Test plan
- **Reset:** assert `rst` mid-stream with 2 beats held → next cycle `outValid=0`, `inReady=1`, `illegalCount=0`, all outputs 0.
- **SUB:** `instr=0x40208033` (sub x0,x1,x2), `rs1Data=10`, `rs2Data=3` → one cycle later `outValid=1`, `ALUOp=001`, `operandA=10`, `operandB=3`, `illegal=0`.
- **ADDI:** addi imm 0xFFF (`instr=0xFFF08093`), `rs1Data=5` → `ALUOp=000`, `operandB=0xFFFFFFFF`, `rdAddr=1`.
- **SRAI:** srai shamt 4 (`instr=0x4040D093`) → `ALUOp=111`, `operandB=4`. The same instruction with funct7 0100001 → `illegal=1`, `illegalCount=1`.
- **Backpressure:** 4 back-to-back beats A–D with `outReady=0` for 3 cycles → A on output, B in skid, `inReady=0`. Then `outReady=1` → A, B, C, D delivered in order; no loss, no duplication.
- **SLT:** SLT (funct3 010) → `illegal=1`, `ALUOp=000`, operands 0. With `ALU_ISSUE_IMM_EN` undefined, ADDI → `illegal=1`.
